// File: rtl/alu_op_sequencer.sv
// Drives one ALU request at a time through a fixed settle window, captures the result and flags,
// then issues a one-cycle writeback and a masked F-register update. Busy requests are not accepted.
module alu_op_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [7:0]  F_RESET       = 8'h00
) (
   input  logic        clk,
   input  logic        notReset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_op,
   input  logic [4:0]  req_src_high,
   input  logic [5:0]  req_src_low,
   input  logic [3:0]  req_dst,
   input  logic        req_is16,
   input  logic [7:0]  req_flag_mask,
   output logic [18:0] alu_op,
   output logic [4:0]  alu_sel_high,
   output logic [5:0]  alu_sel_low,
   output logic        alu_flag_c,
   input  logic [15:0] alu_notResult,
   input  logic        alu_notCY4,
   input  logic        alu_notCY8,
   input  logic        alu_CY16,
   input  logic        alu_is8bitOverflow,
   input  logic        alu_is16bitOverflow,
   input  logic        alu_notIs8bitEvenParity,
   output logic        wb_valid,
   output logic [3:0]  wb_dst,
   output logic [15:0] wb_data,
   output logic [7:0]  flag_f
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      WB    = 2'd2
   } state_t;

   localparam logic [3:0]  LAST_CNT = 4'(SETTLE_CYCLES - 1);
   localparam logic [18:0] OP_NOP   = 19'h1;
   localparam logic [4:0]  OP_MAX   = 5'd18;

   state_t        state_q;
   logic [3:0]    cnt_q;
   logic [4:0]    op_q;
   logic [3:0]    dst_q;
   logic          is16_q;
   logic [7:0]    mask_q;
   logic [18:0]   alu_op_q;
   logic [4:0]    sel_high_q;
   logic [5:0]    sel_low_q;
   logic          flag_c_q;
   logic          req_ready_q;
   logic          wb_valid_q;
   logic [3:0]    wb_dst_q;
   logic [15:0]   wb_data_q;
   logic [7:0]    cf_q;
   logic [7:0]    flag_f_q;

   logic [15:0]   result_d;
   logic [7:0]    cf_d;
   logic          op_live_d;
   logic          is_sub_d;
   logic          is_arith_d;
   logic          carry_d;
   logic          half_d;

   // Flags are derived from the live ALU outputs; they are only sampled on the last settle count.
   always_comb begin
      result_d   = ~alu_notResult;
      op_live_d  = (op_q != 5'd0) && (op_q <= OP_MAX);
      is_sub_d   = (op_q == 5'd3) || (op_q == 5'd4);
      is_arith_d = (op_q >= 5'd1) && (op_q <= 5'd4);
      carry_d    = is16_q ? alu_CY16 : ~alu_notCY8;
      half_d     = ~alu_notCY4;
      cf_d       = 8'h00;
      cf_d[7]    = is16_q ? result_d[15] : result_d[7];
      cf_d[6]    = is16_q ? (result_d == 16'h0000) : (result_d[7:0] == 8'h00);
      cf_d[5]    = result_d[5];
      cf_d[4]    = is_sub_d ? ~half_d : half_d;
      cf_d[3]    = result_d[3];
      cf_d[2]    = is_arith_d ? (is16_q ? alu_is16bitOverflow : alu_is8bitOverflow)
                              : ~alu_notIs8bitEvenParity;
      cf_d[1]    = is_sub_d;
      cf_d[0]    = is_sub_d ? ~carry_d : carry_d;
   end

   always_ff @(posedge clk or negedge notReset) begin
      if (!notReset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         op_q        <= 5'd0;
         dst_q       <= 4'd0;
         is16_q      <= 1'b0;
         mask_q      <= 8'h00;
         alu_op_q    <= OP_NOP;
         sel_high_q  <= 5'd0;
         sel_low_q   <= 6'd0;
         flag_c_q    <= 1'b0;
         req_ready_q <= 1'b1;
         wb_valid_q  <= 1'b0;
         wb_dst_q    <= 4'd0;
         wb_data_q   <= 16'h0000;
         cf_q        <= 8'h00;
         flag_f_q    <= F_RESET;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready_q) begin
                  op_q        <= req_op;
                  dst_q       <= req_dst;
                  is16_q      <= req_is16;
                  mask_q      <= req_flag_mask;
                  // An out-of-range op keeps the ALU on NOP; the request is still consumed.
                  alu_op_q    <= (req_op <= OP_MAX) ? (19'd1 << req_op) : OP_NOP;
                  sel_high_q  <= req_src_high;
                  sel_low_q   <= req_src_low;
                  flag_c_q    <= flag_f_q[0];
                  req_ready_q <= 1'b0;
                  cnt_q       <= 4'd0;
                  state_q     <= DRIVE;
               end
            end
            DRIVE: begin
               if (cnt_q == LAST_CNT) begin
                  wb_data_q  <= is16_q ? result_d : {8'h00, result_d[7:0]};
                  wb_dst_q   <= dst_q;
                  wb_valid_q <= op_live_d && (dst_q != 4'hF);
                  cf_q       <= cf_d;
                  state_q    <= WB;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            WB: begin
               wb_valid_q <= 1'b0;
               if (op_live_d) begin
                  flag_f_q <= (flag_f_q & ~mask_q) | (cf_q & mask_q);
               end
               alu_op_q    <= OP_NOP;
               sel_high_q  <= 5'd0;
               sel_low_q   <= 6'd0;
               flag_c_q    <= 1'b0;
               req_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               wb_valid_q  <= 1'b0;
               alu_op_q    <= OP_NOP;
            end
         endcase
      end
   end

   assign req_ready    = req_ready_q;
   assign alu_op       = alu_op_q;
   assign alu_sel_high = sel_high_q;
   assign alu_sel_low  = sel_low_q;
   assign alu_flag_c   = flag_c_q;
   assign wb_valid     = wb_valid_q;
   assign wb_dst       = wb_dst_q;
   assign wb_data      = wb_data_q;
   assign flag_f       = flag_f_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vector table, back-to-back and reset-abort sequences,
// then random requests checked against a flag/writeback model.
module tb_alu_op_sequencer;

   localparam int unsigned S = 2;

   logic        clk = 1'b0;
   logic        notReset;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_op;
   logic [4:0]  req_src_high;
   logic [5:0]  req_src_low;
   logic [3:0]  req_dst;
   logic        req_is16;
   logic [7:0]  req_flag_mask;
   logic [18:0] alu_op;
   logic [4:0]  alu_sel_high;
   logic [5:0]  alu_sel_low;
   logic        alu_flag_c;
   logic [15:0] alu_notResult;
   logic        alu_notCY4, alu_notCY8, alu_CY16;
   logic        alu_is8bitOverflow, alu_is16bitOverflow, alu_notIs8bitEvenParity;
   logic        wb_valid;
   logic [3:0]  wb_dst;
   logic [15:0] wb_data;
   logic [7:0]  flag_f;

   int errors = 0;
   int checks = 0;
   logic [7:0] f_model = 8'h00;

   alu_op_sequencer #(.SETTLE_CYCLES(S), .F_RESET(8'h00)) dut (
      .clk(clk), .notReset(notReset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_src_high(req_src_high), .req_src_low(req_src_low), .req_dst(req_dst),
      .req_is16(req_is16), .req_flag_mask(req_flag_mask),
      .alu_op(alu_op), .alu_sel_high(alu_sel_high), .alu_sel_low(alu_sel_low),
      .alu_flag_c(alu_flag_c), .alu_notResult(alu_notResult),
      .alu_notCY4(alu_notCY4), .alu_notCY8(alu_notCY8), .alu_CY16(alu_CY16),
      .alu_is8bitOverflow(alu_is8bitOverflow), .alu_is16bitOverflow(alu_is16bitOverflow),
      .alu_notIs8bitEvenParity(alu_notIs8bitEvenParity),
      .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data), .flag_f(flag_f)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  op;
      logic [4:0]  sh;
      logic [5:0]  sl;
      logic [3:0]  dst;
      logic        is16;
      logic [7:0]  mask;
      logic [15:0] nres;
      logic        ncy4, ncy8, cy16, ov8, ov16, npar;
      logic        exp_wb;
      logic [15:0] exp_data;
      logic [7:0]  exp_f;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [4:0] op, input logic is16, input logic [3:0] dst,
                               input logic [7:0] mask, input logic [15:0] nres,
                               input logic ncy4, input logic ncy8, input logic cy16,
                               input logic ov8, input logic ov16, input logic npar,
                               input logic exp_wb, input logic [15:0] exp_data,
                               input logic [7:0] exp_f);
      vec_t v;
      v.op = op; v.is16 = is16; v.dst = dst; v.mask = mask; v.nres = nres;
      v.ncy4 = ncy4; v.ncy8 = ncy8; v.cy16 = cy16; v.ov8 = ov8; v.ov16 = ov16; v.npar = npar;
      v.exp_wb = exp_wb; v.exp_data = exp_data; v.exp_f = exp_f;
      v.sh = 5'd0; v.sl = 6'd0;
      return v;
   endfunction

   // Reference: flags written out from the bit definitions of F using plain arithmetic.
   function automatic vec_t model(input vec_t v, input logic [7:0] f);
      vec_t        o;
      logic [15:0] r;
      logic [15:0] rw;
      int          width, sign, zero, hc, cy, pv, n, c, h, cf;
      bit          sub, arith, live;
      o     = v;
      r     = ~v.nres;
      width = v.is16 ? 16 : 8;
      rw    = v.is16 ? r : (r % 16'd256);
      sign  = (rw >> (width - 1)) & 1;
      zero  = (rw == 0) ? 1 : 0;
      sub   = (v.op == 3 || v.op == 4);
      arith = (v.op >= 1 && v.op <= 4);
      live  = (v.op >= 1 && v.op <= 18);
      cy    = v.is16 ? int'(v.cy16) : 1 - int'(v.ncy8);
      hc    = 1 - int'(v.ncy4);
      c     = sub ? 1 - cy : cy;
      h     = sub ? 1 - hc : hc;
      pv    = arith ? (v.is16 ? int'(v.ov16) : int'(v.ov8)) : 1 - int'(v.npar);
      n     = sub ? 1 : 0;
      cf    = sign * 128 + zero * 64 + int'(r[5]) * 32 + h * 16 + int'(r[3]) * 8
            + pv * 4 + n * 2 + c;
      o.exp_wb   = live && (v.dst != 4'hF);
      o.exp_data = rw;
      o.exp_f    = live ? ((f & ~v.mask) | (8'(cf) & v.mask)) : f;
      return o;
   endfunction

   task automatic apply(input vec_t v, input string tag);
      logic [18:0] oh;
      oh = 19'd1 << v.op;
      @(negedge clk);
      check({tag, " ready_idle"}, req_ready, 1);
      req_op = v.op; req_src_high = v.sh; req_src_low = v.sl; req_dst = v.dst;
      req_is16 = v.is16; req_flag_mask = v.mask;
      alu_notResult = v.nres; alu_notCY4 = v.ncy4; alu_notCY8 = v.ncy8; alu_CY16 = v.cy16;
      alu_is8bitOverflow = v.ov8; alu_is16bitOverflow = v.ov16; alu_notIs8bitEvenParity = v.npar;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      // Request fields are junk after the handshake; the DUT must hold its own copies.
      req_op = 5'($urandom); req_src_high = 5'($urandom); req_src_low = 6'($urandom);
      req_dst = 4'($urandom); req_is16 = 1'($urandom); req_flag_mask = 8'($urandom);
      if (v.op <= 5'd18) check({tag, " alu_op"}, alu_op, oh);
      check({tag, " sel_high"}, alu_sel_high, v.sh);
      check({tag, " sel_low"}, alu_sel_low, v.sl);
      check({tag, " flag_c"}, alu_flag_c, f_model[0]);
      check({tag, " busy"}, req_ready, 0);
      check({tag, " early_wb"}, wb_valid, 0);
      repeat (S) @(negedge clk);
      check({tag, " wb_valid"}, wb_valid, v.exp_wb);
      if (v.exp_wb) begin
         check({tag, " wb_data"}, wb_data, v.exp_data);
         check({tag, " wb_dst"}, wb_dst, v.dst);
      end
      @(negedge clk);
      check({tag, " wb_pulse_end"}, wb_valid, 0);
      check({tag, " ready_back"}, req_ready, 1);
      check({tag, " flag_f"}, flag_f, v.exp_f);
      f_model = v.exp_f;
   endtask

   vec_t vecs[10];

   initial begin
      vec_t rv;
      // op, is16, dst, mask, nres, ncy4, ncy8, cy16, ov8, ov16, npar, exp_wb, exp_data, exp_f
      vecs[0] = mk(5'd1,  0, 4'd1, 8'hFF, 16'hFFFF, 0, 0, 0, 0, 0, 1, 1, 16'h0000, 8'h51);
      vecs[1] = mk(5'd3,  0, 4'd2, 8'hFF, 16'hFFFE, 0, 0, 0, 0, 0, 1, 1, 16'h0001, 8'h02);
      vecs[2] = mk(5'd3,  0, 4'd3, 8'hFF, 16'hFF00, 1, 1, 0, 1, 0, 1, 1, 16'h00FF, 8'hBF);
      vecs[3] = mk(5'd1,  0, 4'd4, 8'h40, 16'hFFFF, 0, 0, 0, 0, 0, 1, 1, 16'h0000, 8'hFF);
      vecs[4] = mk(5'd1,  0, 4'hF, 8'h01, 16'h1234, 0, 1, 0, 0, 0, 1, 0, 16'h0000, 8'hFE);
      vecs[5] = mk(5'd1,  1, 4'd5, 8'hFF, 16'h7FFF, 1, 0, 1, 0, 1, 1, 1, 16'h8000, 8'h85);
      vecs[6] = mk(5'd9,  0, 4'd6, 8'hFF, 16'hFF3C, 0, 1, 0, 0, 0, 0, 1, 16'h00C3, 8'h94);
      vecs[7] = mk(5'd0,  0, 4'd7, 8'hFF, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h94);
      vecs[8] = mk(5'd19, 0, 4'd7, 8'hFF, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h94);
      vecs[9] = mk(5'd6,  0, 4'd8, 8'hFF, 16'h00FF, 1, 1, 0, 0, 0, 0, 1, 16'h0000, 8'h44);

      notReset = 1'b0; req_valid = 1'b0; req_op = 5'd0; req_src_high = 5'd0; req_src_low = 6'd0;
      req_dst = 4'd0; req_is16 = 1'b0; req_flag_mask = 8'h00; alu_notResult = 16'hFFFF;
      alu_notCY4 = 1'b1; alu_notCY8 = 1'b1; alu_CY16 = 1'b0; alu_is8bitOverflow = 1'b0;
      alu_is16bitOverflow = 1'b0; alu_notIs8bitEvenParity = 1'b1;

      // Reset state while held and after release
      repeat (3) @(negedge clk);
      check("rst ready", req_ready, 1);
      check("rst alu_op", alu_op, 19'h1);
      check("rst wb_valid", wb_valid, 0);
      check("rst flag_f", flag_f, 8'h00);
      check("rst wb_data", wb_data, 0);
      check("rst sel", {alu_sel_high, alu_sel_low, alu_flag_c}, 0);
      notReset = 1'b1;
      @(negedge clk);
      check("rel ready", req_ready, 1);
      check("rel alu_op", alu_op, 19'h1);
      check("rel wb_valid", wb_valid, 0);

      for (int i = 0; i < 10; i++) begin
         vecs[i].sh = 5'(i * 3 + 1);
         vecs[i].sl = 6'(i * 5 + 2);
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      // Back-to-back ADDs with req_valid held high
      @(negedge clk);
      req_op = 5'd1; req_dst = 4'd1; req_flag_mask = 8'h00; req_is16 = 1'b0; req_valid = 1'b1;
      for (int t = 0; t < 9; t++) begin
         if (t > 0) @(negedge clk);
         check($sformatf("b2b T%0d ready", t), req_ready, (t % 4 == 0) ? 1 : 0);
         check($sformatf("b2b T%0d wb_valid", t), wb_valid, (t == 3 || t == 7) ? 1 : 0);
         check($sformatf("b2b T%0d alu_op", t), alu_op, (t % 4 == 0) ? 19'h1 : 19'h2);
         if (t == 5) req_valid = 1'b0;
      end
      check("b2b flag_f", flag_f, f_model);

      // Reset pulse during DRIVE aborts the op
      @(negedge clk);
      req_op = 5'd1; req_dst = 4'd2; req_flag_mask = 8'hFF; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check("abort driving", alu_op, 19'h2);
      notReset = 1'b0;
      #1;
      check("abort wb_valid", wb_valid, 0);
      check("abort ready", req_ready, 1);
      check("abort alu_op", alu_op, 19'h1);
      check("abort flag_f", flag_f, 8'h00);
      @(negedge clk);
      notReset = 1'b1;
      f_model = 8'h00;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         check($sformatf("abort post%0d wb_valid", t), wb_valid, 0);
         check($sformatf("abort post%0d ready", t), req_ready, 1);
         check($sformatf("abort post%0d flag_f", t), flag_f, 8'h00);
      end

      // Random requests against the reference model
      for (int i = 0; i < 60; i++) begin
         rv.op   = 5'($urandom_range(0, 20));
         rv.sh   = 5'($urandom);
         rv.sl   = 6'($urandom);
         rv.dst  = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
         rv.is16 = 1'($urandom);
         rv.mask = 8'($urandom);
         rv.nres = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         rv.ncy4 = 1'($urandom); rv.ncy8 = 1'($urandom); rv.cy16 = 1'($urandom);
         rv.ov8  = 1'($urandom); rv.ov16 = 1'($urandom); rv.npar = 1'($urandom);
         rv = model(rv, f_model);
         apply(rv, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
